// File: rtl/rom_stream_pkg.sv
// Shared constants and helpers for the ROM-to-stream burst reader.
package rom_stream_pkg;

    // Content key of the reference ROM: ROM[i] = i ^ ROM_KEY.
    localparam logic [7:0] ROM_KEY = 8'hA5;

    // A read may be issued only if its word is guaranteed a FIFO slot on arrival.
    function automatic logic has_room(input int count, input int inflight, input int depth);
        return (count + inflight) < depth;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock show-ahead FIFO; rd_data always presents the oldest stored word.
module fifo_sync #(
    parameter int DATAW = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [DATAW-1:0]         wr_data,
    output logic [DATAW-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATAW-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rom_sync.sv
// Synchronous reference ROM with one-cycle read latency; ROM[i] = i ^ ROM_KEY.
module rom_sync
    import rom_stream_pkg::*;
#(
    parameter int ADDRW = 7,
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic [ADDRW-1:0] addr,
    output logic [DATAW-1:0] data
);
    always_ff @(posedge clk) begin
        data <= DATAW'(addr) ^ DATAW'(ROM_KEY);
    end

endmodule

// File: rtl/rom_stream.sv
// Streams a burst of consecutive ROM words out of a synchronous ROM onto a
// valid/ready port, with a small FIFO absorbing the ROM read latency.
module rom_stream
    import rom_stream_pkg::*;
#(
    parameter int ADDRW      = 7,
    parameter int DATAW      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ADDRW-1:0] base,
    input  logic [ADDRW:0]   len,
    output logic             busy,
    output logic             done,
    output logic [ADDRW-1:0] rom_addr,
    input  logic [DATAW-1:0] rom_data,
    output logic [DATAW-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       state, state_next;
    logic [ADDRW:0]   issue_left, beats_left;
    logic [1:0]       inflight;
    logic             issue, issue_q;
    logic             pop, beat, last_beat;
    logic [CW-1:0]    fifo_count;
    logic [DATAW-1:0] fifo_data;

    // Stream handshake: a beat moves on a posedge where m_valid and m_ready
    // are both high; m_valid/m_data are registered and hold until that beat.
    assign beat      = m_valid && m_ready;
    assign last_beat = beat && (beats_left == (ADDRW+1)'(1));
    assign pop       = (fifo_count != '0) && (!m_valid || m_ready);
    assign issue     = (state == S_RUN) && (issue_left != '0)
                       && has_room(int'(fifo_count), int'(inflight), FIFO_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: if (start) state_next = (len == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                busy = 1'b1;
                if (last_beat) state_next = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ROM data for a read issued in cycle k arrives in cycle k+1 and is
    // written to the FIFO at the following edge, so issue_q is the write enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr   <= '0;
            issue_left <= '0;
            beats_left <= '0;
            issue_q    <= 1'b0;
            inflight   <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
        end else begin
            issue_q  <= issue;
            inflight <= inflight + 2'(issue) - 2'(issue_q);
            if (state == S_IDLE && start) begin
                rom_addr   <= base;
                issue_left <= len;
                beats_left <= len;
            end else begin
                if (issue) begin
                    rom_addr   <= rom_addr + ADDRW'(1);
                    issue_left <= issue_left - (ADDRW+1)'(1);
                end
                if (beat) beats_left <= beats_left - (ADDRW+1)'(1);
            end
            if (pop) begin
                m_valid <= 1'b1;
                m_data  <= fifo_data;
            end else if (beat) begin
                m_valid <= 1'b0;
            end
        end
    end

    fifo_sync #(
        .DATAW (DATAW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (issue_q),
        .rd_en   (pop),
        .wr_data (rom_data),
        .rd_data (fifo_data),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_rom_stream.sv
// Directed bench for rom_stream paired with rom_sync: a queue model of the
// expected beat order plus literal cycle tables for timing-critical bursts.
module tb_rom_stream;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [6:0] base;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic [6:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    logic [7:0] exp_q[$];
    int         pass_cnt   = 0;
    int         total_cnt  = 0;
    int         done_cnt   = 0;
    int         beats_seen = 0;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = '0;

    rom_stream #(.ADDRW(7), .DATAW(8), .FIFO_DEPTH(4)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    rom_sync #(.ADDRW(7), .DATAW(8)) u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model: a burst yields ROM[(base+i) mod 128] = ((base+i) mod 128) ^ A5.
    task automatic start_burst(input logic [6:0] b, input logic [7:0] l);
        for (int i = 0; i < int'(l); i++) exp_q.push_back(8'((int'(b) + i) % 128) ^ 8'hA5);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cnt < target) begin
            total_cnt++;
            $display("FAIL wait_done: done count %0d, expected %0d within %0d cycles", done_cnt, target, budget);
        end
    endtask

    // Compare process: sampled mid-cycle, predicting the next posedge handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_pend = 1'b0;
        end else begin
            if (stall_pend) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, stall_data);
            end
            if (m_valid && m_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL extra_beat: got beat %0h, expected no beat", m_data);
                end else begin
                    check("beat_data", m_data, exp_q.pop_front());
                end
            end
            stall_pend = m_valid && !m_ready;
            stall_data = m_data;
            if (done) done_cnt++;
            if (busy && done) begin
                total_cnt++;
                $display("FAIL busy_done_overlap: got busy=1 done=1, expected exclusive");
            end
        end
    end

    initial begin
        logic [7:0] a_data [4];
        logic [6:0] b_addr [7];
        int         n;
        int         d_before;
        a_data = '{8'hB5, 8'hB4, 8'hB7, 8'hB6};
        b_addr = '{7'h7E, 7'h7F, 7'h00, 7'h01, 7'h02, 7'h02, 7'h02};

        rst_n = 1'b0; start = 1'b0; base = '0; len = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        check("rst_addr", rom_addr, 0);
        rst_n = 1'b1;

        // Burst 0x10/4: first valid 3 cycles after start, back-to-back beats.
        start_burst(7'h10, 8'd4);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("a_valid", m_valid, (k >= 3 && k <= 6));
            if (k >= 3 && k <= 6) check("a_data", m_data, a_data[k-3]);
            check("a_done", done, (k == 7));
            check("a_busy", busy, (k <= 6));
        end
        check("a_done_cnt", done_cnt, 1);

        // Burst 0x7E/4: address wraps 7F->00 and holds once issuing ends.
        start_burst(7'h7E, 8'd4);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("b_addr", rom_addr, b_addr[k]);
        end
        wait_done(2, 50);
        repeat (3) @(posedge clk);
        #1;
        check("b_done_cnt", done_cnt, 2);
        check("b_queue", exp_q.size(), 0);

        // Full-ROM burst under random backpressure.
        beats_seen = 0;
        start_burst(7'h00, 8'd128);
        n = 0;
        while (done_cnt < 3 && n < 3000) begin
            @(posedge clk); #1;
            m_ready = 1'($urandom_range(0, 1));
            n++;
        end
        m_ready = 1'b1;
        if (done_cnt < 3) begin
            total_cnt++;
            $display("FAIL c_timeout: done count %0d, expected 3", done_cnt);
        end
        check("c_beats", beats_seen, 128);
        check("c_queue", exp_q.size(), 0);

        // Zero-length burst: done only, no busy, no beats.
        @(posedge clk); #1;
        start = 1'b1; base = 7'h33; len = 8'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_valid", m_valid, 0);
        @(negedge clk);
        check("z_done_off", done, 0);
        check("z_busy_off", busy, 0);
        check("z_valid_off", m_valid, 0);
        check("z_done_cnt", done_cnt, 4);

        // A start raised while busy must be ignored.
        start_burst(7'h20, 8'd3);
        @(posedge clk); #1;
        start = 1'b1; base = 7'h40; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(5, 50);
        repeat (10) @(posedge clk);
        #1;
        check("d_done_cnt", done_cnt, 5);
        check("d_queue", exp_q.size(), 0);
        check("d_busy", busy, 0);

        // Reset at the 5th beat of a 20-word burst abandons it.
        beats_seen = 0;
        start_burst(7'h30, 8'd20);
        n = 0;
        while (!(beats_seen >= 4 && m_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(beats_seen >= 4 && m_valid)) begin
            total_cnt++;
            $display("FAIL e_reach: beats %0d, expected 4 beats then a valid 5th", beats_seen);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_valid", m_valid, 0);
        check("e_rst_data", m_data, 0);
        check("e_rst_busy", busy, 0);
        check("e_rst_done", done, 0);
        check("e_rst_addr", rom_addr, 0);
        exp_q.delete();
        d_before = done_cnt;
        beats_seen = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("e_no_beat", beats_seen, 0);
        check("e_no_done", done_cnt, d_before);

        start_burst(7'h01, 8'd2);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check("f_valid", m_valid, (k == 3 || k == 4));
            if (k == 3) check("f_data0", m_data, 8'hA4);
            if (k == 4) check("f_data1", m_data, 8'hA7);
            check("f_done", done, (k == 5));
        end
        check("f_done_cnt", done_cnt, d_before + 1);
        check("f_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
